map_scroll_renderer: RTL and testbench

- Parametrised background renderer for the VGA path.
- Maps the screen pixel (DrawX, DrawY) to a low-resolution source-map coordinate using an integer power-of-two upscale and per-frame scroll offsets with toroidal wrap.
- Issues the address to an external synchronous map ROM, runs the returned index through an external combinational palette, and drives registered 4-bit RGB.
- Delays blank and flags internally so that every output of one pixel leaves together; also emits an opaque flag for sprite/tank compositing downstream.

---
 rtl/map_scroll_renderer.sv | 128 ++++++++++++
 tb/tb_map_scroll_renderer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_scroll_renderer.sv
// Scrolling background renderer: screen pixel -> wrapped source-map address -> ROM -> palette -> registered RGB.
// Blank and in-range flags are delayed alongside the ROM read so one pixel's outputs leave together.
module map_scroll_renderer #(
  parameter int SRC_W       = 320,
  parameter int SRC_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int IDX_W       = 2,
  parameter int ROM_LAT     = 1,
  parameter int ADDR_W      = 17,
  parameter int TRANSP_IDX  = 0
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [8:0]        scroll_x_in,
  input  logic [7:0]        scroll_y_in,
  input  logic              scroll_load,
  output logic              scroll_err,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              opaque
);

  localparam int          AW1     = ADDR_W + 1;
  localparam logic [10:0] SRC_W_L = 11'(SRC_W);
  localparam logic [10:0] SRC_H_L = 11'(SRC_H);

  logic [8:0]        stg_x_q, stg_x_d, act_x_q, act_x_d;
  logic [7:0]        stg_y_q, stg_y_d, act_y_q, act_y_d;
  logic              scroll_err_q, scroll_err_d;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic [ROM_LAT:0]  act_dly_q, act_dly_d;
  logic [3:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic              opaque_q, opaque_d;

  logic              frame_start, load_ok, in_range;
  logic [10:0]       hx, hy, sx_sum, sy_sum, sx, sy;

  always_comb begin
    stg_x_d      = stg_x_q;
    stg_y_d      = stg_y_q;
    scroll_err_d = 1'b0;
    frame_start  = (DrawX == 10'd0) && (DrawY == 10'd0);
    load_ok      = ({2'b00, scroll_x_in} < SRC_W_L) && ({3'b000, scroll_y_in} < SRC_H_L);
    if (scroll_load) begin
      if (load_ok) begin
        stg_x_d = scroll_x_in;
        stg_y_d = scroll_y_in;
      end else begin
        scroll_err_d = 1'b1;
      end
    end

    // Commit at frame start uses the pre-load staged value; the frame-start
    // pixel itself already renders with the newly committed offset.
    act_x_d = frame_start ? stg_x_q : act_x_q;
    act_y_d = frame_start ? stg_y_q : act_y_q;

    hx       = 11'(DrawX >> SCALE_SHIFT);
    hy       = 11'(DrawY >> SCALE_SHIFT);
    in_range = (hx < SRC_W_L) && (hy < SRC_H_L);

    sx_sum = hx + {2'b00, act_x_d};
    sy_sum = hy + {3'b000, act_y_d};
    sx     = (sx_sum >= SRC_W_L) ? (sx_sum - SRC_W_L) : sx_sum;
    sy     = (sy_sum >= SRC_H_L) ? (sy_sum - SRC_H_L) : sy_sum;

    rom_address_d = in_range ? ADDR_W'(AW1'(sy) * AW1'(SRC_W) + AW1'(sx)) : '0;
    act_dly_d     = {act_dly_q[ROM_LAT-1:0], blank & in_range};

    red_d    = 4'd0;
    green_d  = 4'd0;
    blue_d   = 4'd0;
    opaque_d = 1'b0;
    if (act_dly_q[ROM_LAT]) begin
      red_d    = pal_red;
      green_d  = pal_green;
      blue_d   = pal_blue;
      opaque_d = (rom_q != IDX_W'(TRANSP_IDX));
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      stg_x_q       <= '0;
      stg_y_q       <= '0;
      act_x_q       <= '0;
      act_y_q       <= '0;
      scroll_err_q  <= 1'b0;
      rom_address_q <= '0;
      act_dly_q     <= '0;
      red_q         <= 4'd0;
      green_q       <= 4'd0;
      blue_q        <= 4'd0;
      opaque_q      <= 1'b0;
    end else begin
      stg_x_q       <= stg_x_d;
      stg_y_q       <= stg_y_d;
      act_x_q       <= act_x_d;
      act_y_q       <= act_y_d;
      scroll_err_q  <= scroll_err_d;
      rom_address_q <= rom_address_d;
      act_dly_q     <= act_dly_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      opaque_q      <= opaque_d;
    end
  end

  assign scroll_err  = scroll_err_q;
  assign rom_address = rom_address_q;
  assign pal_index   = rom_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign opaque      = opaque_q;

endmodule

// File: tb/tb_map_scroll_renderer.sv
// Bench for map_scroll_renderer: two instances (ROM latency 1 and 3) share stimulus;
// expected address/colour/flags are queued per driven pixel and compared against captured outputs.
module tb_map_scroll_renderer;

  logic        vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [8:0]  scroll_x_in;
  logic [7:0]  scroll_y_in;
  logic        scroll_load;

  logic        err1, err3;
  logic [16:0] addr1, addr3;
  logic [1:0]  q1, q3, pidx1, pidx3;
  logic [3:0]  pr1, pg1, pb1, pr3, pg3, pb3;
  logic [3:0]  r1, g1, b1, r3, g3, b3;
  logic        opq1, opq3;

  map_scroll_renderer #(.ROM_LAT(1)) dut1 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .scroll_x_in(scroll_x_in), .scroll_y_in(scroll_y_in), .scroll_load(scroll_load),
    .scroll_err(err1), .rom_address(addr1), .rom_q(q1), .pal_index(pidx1),
    .pal_red(pr1), .pal_green(pg1), .pal_blue(pb1),
    .red(r1), .green(g1), .blue(b1), .opaque(opq1));

  map_scroll_renderer #(.ROM_LAT(3)) dut3 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .scroll_x_in(scroll_x_in), .scroll_y_in(scroll_y_in), .scroll_load(scroll_load),
    .scroll_err(err3), .rom_address(addr3), .rom_q(q3), .pal_index(pidx3),
    .pal_red(pr3), .pal_green(pg3), .pal_blue(pb3),
    .red(r3), .green(g3), .blue(b3), .opaque(opq3));

  function automatic logic [1:0] rom_fn(input logic [16:0] a);
    return a[1:0] ^ a[3:2];
  endfunction

  function automatic logic [11:0] pal(input logic [1:0] i);
    return {i, 2'b10, 2'b01, i, ~i, ~i};
  endfunction

  // ROM models with latency 1 and 3, palettes combinational
  logic [1:0] rq1, rq3a, rq3b, rq3c;
  always @(posedge vga_clk) begin
    rq1  <= rom_fn(addr1);
    rq3a <= rom_fn(addr3);
    rq3b <= rq3a;
    rq3c <= rq3b;
  end
  assign q1 = rq1;
  assign q3 = rq3c;
  assign {pr1, pg1, pb1} = pal(pidx1);
  assign {pr3, pg3, pb3} = pal(pidx3);

  // cycle counter and per-cycle output history
  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  logic [16:0] a1_h [0:4095];
  logic [16:0] a3_h [0:4095];
  logic [11:0] c1_h [0:4095];
  logic [11:0] c3_h [0:4095];
  logic        o1_h [0:4095];
  logic        o3_h [0:4095];
  logic        e1_h [0:4095];
  logic        e3_h [0:4095];

  always @(negedge vga_clk) begin
    if (cyc < 4096) begin
      a1_h[cyc] = addr1;  a3_h[cyc] = addr3;
      c1_h[cyc] = {r1, g1, b1};  c3_h[cyc] = {r3, g3, b3};
      o1_h[cyc] = opq1;  o3_h[cyc] = opq3;
      e1_h[cyc] = err1;  e3_h[cyc] = err3;
    end
  end

  typedef struct {
    int          k;
    logic [16:0] addr;
    logic        err;
    logic [11:0] c1;
    logic        o1;
    logic [11:0] c3;
    logic        o3;
  } exp_t;

  exp_t sbq[$];
  int   m_sx, m_sy, m_ax, m_ay;
  int   n_vec = 0;
  int   n_fail = 0;

  // Drive one pixel for one cycle and queue its expected results.
  task automatic drv(input int x, input int y, input logic b, input logic ld,
                     input int lsx, input int lsy, input logic rst);
    exp_t e;
    int hx, hy, ex, ey;
    logic fs, inr, act, ok;
    logic [1:0] idx;
    DrawX = 10'(x); DrawY = 10'(y); blank = b; scroll_load = ld;
    scroll_x_in = 9'(lsx); scroll_y_in = 8'(lsy); reset = rst;
    e.k = cyc;
    if (rst) begin
      m_sx = 0; m_sy = 0; m_ax = 0; m_ay = 0;
      e.addr = '0; e.err = 1'b0; e.c1 = '0; e.o1 = 1'b0; e.c3 = '0; e.o3 = 1'b0;
      foreach (sbq[i]) begin
        if (sbq[i].k + 3 > cyc) begin sbq[i].c1 = '0; sbq[i].o1 = 1'b0; end
        if (sbq[i].k + 5 > cyc) begin sbq[i].c3 = '0; sbq[i].o3 = 1'b0; end
      end
    end else begin
      fs  = (x == 0) && (y == 0);
      ex  = fs ? m_sx : m_ax;
      ey  = fs ? m_sy : m_ay;
      hx  = x >> 1;
      hy  = y >> 1;
      inr = (hx < 320) && (hy < 240);
      e.addr = inr ? 17'((((hy + ey) % 240) * 320) + ((hx + ex) % 320)) : 17'd0;
      act = b && inr;
      idx = rom_fn(e.addr);
      e.c1 = act ? pal(idx) : 12'd0;
      e.o1 = act && (idx != 2'd0);
      e.c3 = e.c1;
      e.o3 = e.o1;
      ok = (lsx < 320) && (lsy < 240);
      e.err = ld && !ok;
      if (fs) begin m_ax = m_sx; m_ay = m_sy; end
      if (ld && ok) begin m_sx = lsx; m_sy = lsy; end
    end
    sbq.push_back(e);
    @(posedge vga_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(640, 500, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) drv(640, 500, 1'b0, 1'b0, 0, 0, 1'b1);
    n_vec++; if (addr1 !== 17'd0) begin n_fail++; $display("FAIL reset_addr1: got %0h expected 0", addr1); end
    n_vec++; if (addr3 !== 17'd0) begin n_fail++; $display("FAIL reset_addr3: got %0h expected 0", addr3); end
    n_vec++; if ({r1, g1, b1} !== 12'd0) begin n_fail++; $display("FAIL reset_rgb1: got %0h expected 0", {r1, g1, b1}); end
    n_vec++; if ({r3, g3, b3} !== 12'd0) begin n_fail++; $display("FAIL reset_rgb3: got %0h expected 0", {r3, g3, b3}); end
    n_vec++; if (opq1 !== 1'b0) begin n_fail++; $display("FAIL reset_opaque: got %0b expected 0", opq1); end
    n_vec++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", err1); end
  endtask

  task automatic test_basic();
    int k;
    k = cyc;
    drv(5, 3, 1'b1, 1'b0, 0, 0, 1'b0);
    idle(6);
    n_vec++; if (a1_h[k+1] !== 17'd322) begin n_fail++; $display("FAIL basic_addr: got %0d expected 322", a1_h[k+1]); end
    n_vec++; if (c1_h[k+3] !== pal(rom_fn(17'd322))) begin n_fail++; $display("FAIL basic_rgb1: got %0h expected %0h", c1_h[k+3], pal(rom_fn(17'd322))); end
    n_vec++; if (c1_h[k+2] !== 12'd0) begin n_fail++; $display("FAIL basic_early1: got %0h expected 0", c1_h[k+2]); end
    n_vec++; if (o1_h[k+3] !== 1'b1) begin n_fail++; $display("FAIL basic_opaque: got %0b expected 1", o1_h[k+3]); end
    n_vec++; if (c3_h[k+5] !== pal(rom_fn(17'd322))) begin n_fail++; $display("FAIL basic_rgb3: got %0h expected %0h", c3_h[k+5], pal(rom_fn(17'd322))); end
    n_vec++; if (c3_h[k+4] !== 12'd0) begin n_fail++; $display("FAIL basic_early3: got %0h expected 0", c3_h[k+4]); end
  endtask

  task automatic test_wrap();
    int k1, k2;
    drv(640, 500, 1'b0, 1'b1, 300, 0, 1'b0);
    drv(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    k1 = cyc;
    drv(100, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    drv(640, 500, 1'b0, 1'b1, 300, 239, 1'b0);
    drv(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    k2 = cyc;
    drv(100, 479, 1'b1, 1'b0, 0, 0, 1'b0);
    idle(2);
    n_vec++; if (a1_h[k1+1] !== 17'd30) begin n_fail++; $display("FAIL wrap_x: got %0d expected 30", a1_h[k1+1]); end
    n_vec++; if (a3_h[k1+1] !== 17'd30) begin n_fail++; $display("FAIL wrap_x3: got %0d expected 30", a3_h[k1+1]); end
    n_vec++; if (a1_h[k2+1] !== 17'd76190) begin n_fail++; $display("FAIL wrap_xy: got %0d expected 76190", a1_h[k2+1]); end
  endtask

  task automatic test_reject();
    int kr, k;
    kr = cyc;
    drv(640, 500, 1'b0, 1'b1, 320, 0, 1'b0);
    drv(640, 500, 1'b0, 1'b1, 0, 240, 1'b0);
    drv(640, 500, 1'b0, 1'b0, 0, 0, 1'b0);
    drv(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    k = cyc;
    drv(100, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    idle(2);
    n_vec++; if (e1_h[kr+1] !== 1'b1) begin n_fail++; $display("FAIL reject_err_x: got %0b expected 1", e1_h[kr+1]); end
    n_vec++; if (e3_h[kr+2] !== 1'b1) begin n_fail++; $display("FAIL reject_err_y: got %0b expected 1", e3_h[kr+2]); end
    n_vec++; if (e1_h[kr+3] !== 1'b0) begin n_fail++; $display("FAIL reject_err_pulse: got %0b expected 0", e1_h[kr+3]); end
    n_vec++; if (a1_h[k+1] !== 17'd76510) begin n_fail++; $display("FAIL reject_keep: got %0d expected 76510", a1_h[k+1]); end
  endtask

  task automatic test_deferred();
    int k1, kf, k2, kc, k3, kf2;
    drv(640, 500, 1'b0, 1'b1, 0, 10, 1'b0);
    k1 = cyc;  drv(100, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    kf = cyc;  drv(0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    k2 = cyc;  drv(100, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    kc = cyc;  drv(0, 0, 1'b1, 1'b1, 5, 5, 1'b0);
    k3 = cyc;  drv(100, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    kf2 = cyc; drv(0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    idle(2);
    n_vec++; if (a1_h[k1+1] !== 17'd76510) begin n_fail++; $display("FAIL defer_hold: got %0d expected 76510", a1_h[k1+1]); end
    n_vec++; if (a1_h[kf+1] !== 17'd3200) begin n_fail++; $display("FAIL defer_commit: got %0d expected 3200", a1_h[kf+1]); end
    n_vec++; if (a1_h[k2+1] !== 17'd3250) begin n_fail++; $display("FAIL defer_after: got %0d expected 3250", a1_h[k2+1]); end
    n_vec++; if (a1_h[kc+1] !== 17'd3200) begin n_fail++; $display("FAIL coincide_old: got %0d expected 3200", a1_h[kc+1]); end
    n_vec++; if (a1_h[k3+1] !== 17'd3250) begin n_fail++; $display("FAIL coincide_hold: got %0d expected 3250", a1_h[k3+1]); end
    n_vec++; if (a1_h[kf2+1] !== 17'd1605) begin n_fail++; $display("FAIL coincide_next: got %0d expected 1605", a1_h[kf2+1]); end
  endtask

  task automatic test_blank_transp();
    int kb, kt, ko, kp;
    kb = cyc; drv(6, 20, 1'b0, 1'b0, 0, 0, 1'b0);
    kt = cyc; drv(0, 20, 1'b1, 1'b0, 0, 0, 1'b0);
    ko = cyc; drv(6, 20, 1'b1, 1'b0, 0, 0, 1'b0);
    kp = cyc; drv(700, 100, 1'b1, 1'b0, 0, 0, 1'b0);
    idle(6);
    n_vec++; if (a1_h[kb+1] !== 17'd4808) begin n_fail++; $display("FAIL blank_addr: got %0d expected 4808", a1_h[kb+1]); end
    n_vec++; if (c1_h[kb+3] !== 12'd0) begin n_fail++; $display("FAIL blank_rgb: got %0h expected 0", c1_h[kb+3]); end
    n_vec++; if (o1_h[kb+3] !== 1'b0) begin n_fail++; $display("FAIL blank_opaque: got %0b expected 0", o1_h[kb+3]); end
    n_vec++; if (a1_h[kt+1] !== 17'd4805) begin n_fail++; $display("FAIL transp_addr: got %0d expected 4805", a1_h[kt+1]); end
    n_vec++; if (c1_h[kt+3] !== pal(2'd0)) begin n_fail++; $display("FAIL transp_rgb: got %0h expected %0h", c1_h[kt+3], pal(2'd0)); end
    n_vec++; if (o1_h[kt+3] !== 1'b0) begin n_fail++; $display("FAIL transp_opaque: got %0b expected 0", o1_h[kt+3]); end
    n_vec++; if (o1_h[ko+3] !== 1'b1) begin n_fail++; $display("FAIL idx2_opaque: got %0b expected 1", o1_h[ko+3]); end
    n_vec++; if (c3_h[ko+5] !== pal(2'd2)) begin n_fail++; $display("FAIL idx2_rgb3: got %0h expected %0h", c3_h[ko+5], pal(2'd2)); end
    n_vec++; if (a1_h[kp+1] !== 17'd0) begin n_fail++; $display("FAIL porch_addr: got %0d expected 0", a1_h[kp+1]); end
    n_vec++; if (c1_h[kp+3] !== 12'd0) begin n_fail++; $display("FAIL porch_rgb: got %0h expected 0", c1_h[kp+3]); end
  endtask

  task automatic test_latency_reset();
    int kr, kz;
    for (int i = 0; i < 6; i++) drv(20 + 2 * i, 40, 1'b1, 1'b0, 0, 0, 1'b0);
    kr = cyc;
    repeat (2) drv(40, 40, 1'b1, 1'b0, 0, 0, 1'b1);
    kz = cyc;
    drv(20, 40, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 1; i < 6; i++) drv(20 + 2 * i, 40, 1'b1, 1'b0, 0, 0, 1'b0);
    idle(6);
    n_vec++; if (c1_h[kr+1] !== 12'd0) begin n_fail++; $display("FAIL rst_rgb1: got %0h expected 0", c1_h[kr+1]); end
    n_vec++; if (c3_h[kr+1] !== 12'd0) begin n_fail++; $display("FAIL rst_rgb3: got %0h expected 0", c3_h[kr+1]); end
    n_vec++; if (a1_h[kr+1] !== 17'd0) begin n_fail++; $display("FAIL rst_addr: got %0d expected 0", a1_h[kr+1]); end
    n_vec++; if (a1_h[kz+1] !== 17'd6410) begin n_fail++; $display("FAIL rst_scroll0: got %0d expected 6410", a1_h[kz+1]); end
    n_vec++; if (c1_h[kz+2] !== 12'd0) begin n_fail++; $display("FAIL rst_early1: got %0h expected 0", c1_h[kz+2]); end
    n_vec++; if (c1_h[kz+3] !== pal(rom_fn(17'd6410))) begin n_fail++; $display("FAIL rst_first1: got %0h expected %0h", c1_h[kz+3], pal(rom_fn(17'd6410))); end
    n_vec++; if (c3_h[kz+4] !== 12'd0) begin n_fail++; $display("FAIL rst_early3: got %0h expected 0", c3_h[kz+4]); end
    n_vec++; if (c3_h[kz+5] !== pal(rom_fn(17'd6410))) begin n_fail++; $display("FAIL rst_first3: got %0h expected %0h", c3_h[kz+5], pal(rom_fn(17'd6410))); end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    idle(8);
    while (sbq.size() > 0 && sbq[0].k + 5 < cyc) begin
      e = sbq.pop_front();
      n_vec++; if (a1_h[e.k+1] !== e.addr) begin n_fail++; $display("FAIL sb_addr1 @%0d: got %0d expected %0d", e.k, a1_h[e.k+1], e.addr); end
      n_vec++; if (a3_h[e.k+1] !== e.addr) begin n_fail++; $display("FAIL sb_addr3 @%0d: got %0d expected %0d", e.k, a3_h[e.k+1], e.addr); end
      n_vec++; if (e1_h[e.k+1] !== e.err) begin n_fail++; $display("FAIL sb_err1 @%0d: got %0b expected %0b", e.k, e1_h[e.k+1], e.err); end
      n_vec++; if (e3_h[e.k+1] !== e.err) begin n_fail++; $display("FAIL sb_err3 @%0d: got %0b expected %0b", e.k, e3_h[e.k+1], e.err); end
      n_vec++; if (c1_h[e.k+3] !== e.c1) begin n_fail++; $display("FAIL sb_rgb1 @%0d: got %0h expected %0h", e.k, c1_h[e.k+3], e.c1); end
      n_vec++; if (o1_h[e.k+3] !== e.o1) begin n_fail++; $display("FAIL sb_opq1 @%0d: got %0b expected %0b", e.k, o1_h[e.k+3], e.o1); end
      n_vec++; if (c3_h[e.k+5] !== e.c3) begin n_fail++; $display("FAIL sb_rgb3 @%0d: got %0h expected %0h", e.k, c3_h[e.k+5], e.c3); end
      n_vec++; if (o3_h[e.k+5] !== e.o3) begin n_fail++; $display("FAIL sb_opq3 @%0d: got %0b expected %0b", e.k, o3_h[e.k+5], e.o3); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_sx = 0; m_sy = 0; m_ax = 0; m_ay = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_reject();
    test_deferred();
    test_blank_transp();
    test_latency_reset();
    test_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
